// File: rtl/rs_issue_queue_if.sv
// Dispatch, result-bus and issue-stage signals between the dispatch side and the issue queue.
interface rs_issue_queue_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NCDB   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 6
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                     rdy;
  logic                     flush;
  logic                     full;
  logic [CNT_W-1:0]         count;

  logic                     disp_valid;
  logic [OP_W-1:0]          disp_op;
  logic [DATA_W-1:0]        disp_imm;
  logic [DATA_W-1:0]        disp_pc;
  logic                     disp_r1_valid;
  logic [DATA_W-1:0]        disp_r1_data;
  logic [TAG_W-1:0]         disp_r1_tag;
  logic                     disp_r2_valid;
  logic [DATA_W-1:0]        disp_r2_data;
  logic [TAG_W-1:0]         disp_r2_tag;
  logic [TAG_W-1:0]         disp_dest_tag;

  logic [NCDB-1:0]          cdb_valid;
  logic [NCDB*TAG_W-1:0]    cdb_tag;
  logic [NCDB*DATA_W-1:0]   cdb_data;

  logic                     iss_valid;
  logic                     iss_ready;
  logic [OP_W-1:0]          iss_op;
  logic [DATA_W-1:0]        iss_r1;
  logic [DATA_W-1:0]        iss_r2;
  logic [DATA_W-1:0]        iss_imm;
  logic [DATA_W-1:0]        iss_pc;
  logic [TAG_W-1:0]         iss_dest_tag;

  modport master (
    output rdy, flush,
    output disp_valid, disp_op, disp_imm, disp_pc,
    output disp_r1_valid, disp_r1_data, disp_r1_tag,
    output disp_r2_valid, disp_r2_data, disp_r2_tag, disp_dest_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output iss_ready,
    input  full, count,
    input  iss_valid, iss_op, iss_r1, iss_r2, iss_imm, iss_pc, iss_dest_tag
  );

  modport slave (
    input  rdy, flush,
    input  disp_valid, disp_op, disp_imm, disp_pc,
    input  disp_r1_valid, disp_r1_data, disp_r1_tag,
    input  disp_r2_valid, disp_r2_data, disp_r2_tag, disp_dest_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  iss_ready,
    output full, count,
    output iss_valid, iss_op, iss_r1, iss_r2, iss_imm, iss_pc, iss_dest_tag
  );
endinterface

// File: rtl/rs_issue_queue.sv
// Age-ordered reservation station: CDB snooping (incl. dispatch bypass), oldest-ready select,
// registered valid/ready issue stage.
module rs_issue_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NCDB   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 6
) (
  input logic              clk,
  input logic              rst,
  rs_issue_queue_if.slave  io
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  r1_rdy;
  logic [DEPTH-1:0]  r2_rdy;
  logic [OP_W-1:0]   e_op   [DEPTH];
  logic [DATA_W-1:0] e_imm  [DEPTH];
  logic [DATA_W-1:0] e_pc   [DEPTH];
  logic [DATA_W-1:0] e_r1   [DEPTH];
  logic [DATA_W-1:0] e_r2   [DEPTH];
  logic [TAG_W-1:0]  e_r1_tag [DEPTH];
  logic [TAG_W-1:0]  e_r2_tag [DEPTH];
  logic [TAG_W-1:0]  e_dest [DEPTH];
  // older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  older  [DEPTH];
  logic [CNT_W-1:0]  cnt;

  logic              iss_v;
  logic [OP_W-1:0]   iss_op_q;
  logic [DATA_W-1:0] iss_r1_q;
  logic [DATA_W-1:0] iss_r2_q;
  logic [DATA_W-1:0] iss_imm_q;
  logic [DATA_W-1:0] iss_pc_q;
  logic [TAG_W-1:0]  iss_dest_q;

  logic [DEPTH-1:0]  w1_hit;
  logic [DEPTH-1:0]  w2_hit;
  logic [DATA_W-1:0] w1_data [DEPTH];
  logic [DATA_W-1:0] w2_data [DEPTH];
  logic              d1_hit;
  logic              d2_hit;
  logic [DATA_W-1:0] d1_data;
  logic [DATA_W-1:0] d2_data;

  logic [DEPTH-1:0]  ready_v;
  logic [DEPTH-1:0]  sel_oh;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              sel_any;
  logic              load;
  logic              disp_acc;

  // Tag match against every valid bus; walking downwards lets the lowest bus index win.
  always_comb begin
    w1_hit  = '0;
    w2_hit  = '0;
    d1_hit  = 1'b0;
    d2_hit  = 1'b0;
    d1_data = '0;
    d2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w1_data[i] = '0;
      w2_data[i] = '0;
    end
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (io.cdb_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (io.cdb_tag[k*TAG_W +: TAG_W] == e_r1_tag[i]) begin
            w1_hit[i]  = 1'b1;
            w1_data[i] = io.cdb_data[k*DATA_W +: DATA_W];
          end
          if (io.cdb_tag[k*TAG_W +: TAG_W] == e_r2_tag[i]) begin
            w2_hit[i]  = 1'b1;
            w2_data[i] = io.cdb_data[k*DATA_W +: DATA_W];
          end
        end
        if (io.cdb_tag[k*TAG_W +: TAG_W] == io.disp_r1_tag) begin
          d1_hit  = 1'b1;
          d1_data = io.cdb_data[k*DATA_W +: DATA_W];
        end
        if (io.cdb_tag[k*TAG_W +: TAG_W] == io.disp_r2_tag) begin
          d2_hit  = 1'b1;
          d2_data = io.cdb_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign ready_v = vld & r1_rdy & r2_rdy;
  assign sel_any = |ready_v;

  // Oldest ready entry: ready and no other ready entry is older.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = ready_v[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready_v[j] && older[j][i]) sel_oh[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld[i]) free_idx = IDX_W'(i);
    end
  end

  assign io.full  = (cnt == CNT_W'(DEPTH));
  assign io.count = cnt;
  assign disp_acc = io.rdy && io.disp_valid && !io.full;
  assign load     = io.rdy && (!iss_v || io.iss_ready) && sel_any;

  // Occupancy, issue stage and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld        <= '0;
      cnt        <= '0;
      iss_v      <= 1'b0;
      iss_op_q   <= '0;
      iss_r1_q   <= '0;
      iss_r2_q   <= '0;
      iss_imm_q  <= '0;
      iss_pc_q   <= '0;
      iss_dest_q <= '0;
    end else if (io.rdy) begin
      if (io.flush) begin
        vld        <= '0;
        cnt        <= '0;
        iss_v      <= 1'b0;
        iss_op_q   <= '0;
        iss_r1_q   <= '0;
        iss_r2_q   <= '0;
        iss_imm_q  <= '0;
        iss_pc_q   <= '0;
        iss_dest_q <= '0;
      end else begin
        if (load) begin
          vld[sel_idx] <= 1'b0;
          iss_v        <= 1'b1;
          iss_op_q     <= e_op[sel_idx];
          iss_r1_q     <= e_r1[sel_idx];
          iss_r2_q     <= e_r2[sel_idx];
          iss_imm_q    <= e_imm[sel_idx];
          iss_pc_q     <= e_pc[sel_idx];
          iss_dest_q   <= e_dest[sel_idx];
        end else if (io.iss_ready) begin
          iss_v <= 1'b0;
        end
        if (disp_acc) vld[free_idx] <= 1'b1;
        cnt <= cnt + CNT_W'(disp_acc) - CNT_W'(load);
      end
    end
  end

  // Entry payload, operand wakeup and age matrix; only meaningful where vld is set.
  always_ff @(posedge clk) begin
    if (io.rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && !r1_rdy[i] && w1_hit[i]) begin
          r1_rdy[i] <= 1'b1;
          e_r1[i]   <= w1_data[i];
        end
        if (vld[i] && !r2_rdy[i] && w2_hit[i]) begin
          r2_rdy[i] <= 1'b1;
          e_r2[i]   <= w2_data[i];
        end
      end
      if (disp_acc) begin
        e_op[free_idx]     <= io.disp_op;
        e_imm[free_idx]    <= io.disp_imm;
        e_pc[free_idx]     <= io.disp_pc;
        e_dest[free_idx]   <= io.disp_dest_tag;
        e_r1_tag[free_idx] <= io.disp_r1_tag;
        e_r2_tag[free_idx] <= io.disp_r2_tag;
        r1_rdy[free_idx]   <= io.disp_r1_valid || d1_hit;
        r2_rdy[free_idx]   <= io.disp_r2_valid || d2_hit;
        e_r1[free_idx]     <= io.disp_r1_valid ? io.disp_r1_data : d1_data;
        e_r2[free_idx]     <= io.disp_r2_valid ? io.disp_r2_data : d2_data;
        older[free_idx]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (IDX_W'(j) != free_idx) older[j][free_idx] <= 1'b1;
        end
      end
    end
  end

  assign io.iss_valid    = iss_v;
  assign io.iss_op       = iss_op_q;
  assign io.iss_r1       = iss_r1_q;
  assign io.iss_r2       = iss_r2_q;
  assign io.iss_imm      = iss_imm_q;
  assign io.iss_pc       = iss_pc_q;
  assign io.iss_dest_tag = iss_dest_q;
endmodule
